// File: rtl/prim_fifo_burst_rd_pkg.sv
// Shared types and constants for prim_fifo_burst_rd.
//   state_e : read-side sequencer states (IDLE, BURST, DRAIN)
//   TimerW  : width of the partial-burst flush timer
package prim_fifo_burst_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned TimerW = 8;

endpackage

// File: rtl/prim_fifo_burst_rd.sv
// prim_fifo_burst_rd -- burst reader sitting on the read side of a FIFO.
// Waits until the FIFO holds BurstLen words, then pops exactly that many
// words back to back into a one-entry output register, marking the first
// and last beat of each burst. A new burst only starts after the previous
// last beat has been accepted downstream.
//
// Optional feature (macro PRIM_FIFO_BURST_RD_TIMEOUT_EN): when the FIFO
// holds some but fewer than BurstLen words for TimeoutCycles cycles, a
// short burst of the current occupancy is flushed out.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   fifo_rvalid_i  FIFO has data at its head
//   fifo_rready_o  pop strobe to the FIFO (combinational)
//   fifo_rdata_i   FIFO head word
//   fifo_rdepth_i  FIFO occupancy
//   out_valid_o    downstream word valid
//   out_ready_i    downstream accept
//   out_data_o     downstream word
//   out_first_o    first beat of a burst
//   out_last_o     last beat of a burst
//   busy_o         sequencer is not idle
module prim_fifo_burst_rd
    import prim_fifo_burst_rd_pkg::*;
#(
    parameter int Width         = 16,
    parameter int Depth         = 3,
    parameter int DepthW        = $clog2(Depth + 1),
    parameter int BurstLen      = 2,
    parameter int TimeoutCycles = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fifo_rvalid_i,
    output logic              fifo_rready_o,
    input  logic [Width-1:0]  fifo_rdata_i,
    input  logic [DepthW-1:0] fifo_rdepth_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [Width-1:0]  out_data_o,
    output logic              out_first_o,
    output logic              out_last_o,
    output logic              busy_o
);

    localparam logic [DepthW-1:0] BurstThresh = DepthW'(BurstLen);

    state_e            state_reg, state_next;
    // Remaining beats to pop in the current burst; loaded with the burst
    // length on entry to BURST.
    logic [DepthW-1:0] beats_reg, beats_next;
    // Set on burst entry, cleared by the first pop: tags that beat as first.
    logic              first_pend_reg, first_pend_next;

    logic              out_valid_reg, out_valid_next;
    logic [Width-1:0]  out_data_reg, out_data_next;
    logic              out_first_reg, out_first_next;
    logic              out_last_reg, out_last_next;

    logic              pop;
    logic              accept;
    logic              threshold_hit;
    logic              timeout_hit;

    // A pop needs a free output slot: either the register is empty or its
    // word leaves this same cycle, which keeps bursts bubble-free.
    assign pop    = (state_reg == BURST) & fifo_rvalid_i & (beats_reg != '0) &
                    (~out_valid_reg | out_ready_i);
    assign accept = out_valid_reg & out_ready_i;

    assign threshold_hit = (fifo_rdepth_i >= BurstThresh);

`ifdef PRIM_FIFO_BURST_RD_TIMEOUT_EN
    logic [TimerW-1:0] timer_reg, timer_next;
    logic              partial;

    // Counting runs only while idle with a partial burst waiting; any other
    // situation (empty FIFO, full threshold, not IDLE) holds it at zero.
    assign partial     = (state_reg == IDLE) & (fifo_rdepth_i != '0) & ~threshold_hit;
    // The timer value equals the number of cycles already counted, so the
    // flush fires on the TimeoutCycles-th counting cycle.
    assign timeout_hit = partial & (timer_reg == TimerW'(TimeoutCycles - 1));

    always_comb begin
        timer_next = '0;
        if (partial && !timeout_hit) begin
            timer_next = timer_reg + TimerW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        beats_next      = beats_reg;
        first_pend_next = first_pend_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_first_next  = out_first_reg;
        out_last_next   = out_last_reg;

        case (state_reg)
            IDLE: begin
                // Threshold entry wins over a timeout in the same cycle.
                if (threshold_hit) begin
                    state_next      = BURST;
                    beats_next      = BurstThresh;
                    first_pend_next = 1'b1;
                end else if (timeout_hit) begin
                    state_next      = BURST;
                    beats_next      = fifo_rdepth_i;
                    first_pend_next = 1'b1;
                end
            end
            BURST: begin
                if (pop) begin
                    beats_next      = beats_reg - DepthW'(1);
                    first_pend_next = 1'b0;
                    if (beats_reg == DepthW'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (pop) begin
            out_valid_next = 1'b1;
            out_data_next  = fifo_rdata_i;
            out_first_next = first_pend_reg;
            out_last_next  = (beats_reg == DepthW'(1));
        end else if (accept) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            beats_reg      <= '0;
            first_pend_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_first_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beats_reg      <= beats_next;
            first_pend_reg <= first_pend_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_first_reg  <= out_first_next;
            out_last_reg   <= out_last_next;
        end
    end

    assign fifo_rready_o = pop;
    assign out_valid_o   = out_valid_reg;
    assign out_data_o    = out_data_reg;
    assign out_first_o   = out_first_reg;
    assign out_last_o    = out_last_reg;
    assign busy_o        = (state_reg != IDLE);

endmodule
